prescaled_updown_counter: RTL and testbench
===========================================

PRESCALED_UPDOWN_COUNTER -- requirements
Module: prescaled_updown_counter

Interface
REQ-001 Parameter WIDTH, default 16, counter width in bits (>= 2).
REQ-002 Parameter PRESCALE, default 4, clock-enable divide ratio (>= 1).
REQ-003 Parameter WRAP, default 1: 1 = wrap-around mode, 0 = saturate mode.
REQ-004 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset_  input  1  reset, synchronous, active-high.
REQ-006 Port enable  input  1  advances prescaler when high; freezes prescaler and counter when low.
REQ-007 Port up  input  1  count direction: 1 = increment, 0 = decrement.
REQ-008 Port load  input  1  synchronous parallel load request.
REQ-009 Port load_value  input  WIDTH  value taken by counter on load.
REQ-010 Port counter  output  WIDTH  registered count value.
REQ-011 Port tick  output  1  combinational prescaler strobe.
REQ-012 Port terminal  output  1  combinational pulse: boundary reached on this tick.
REQ-013 Port saturated  output  1  registered flag: counter held at a limit (saturate mode only).

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1, incrementing on each edge with enable high, returning to 0 after PRESCALE-1.
REQ-015 tick SHALL equal enable AND (prescaler == PRESCALE-1); with PRESCALE = 1, tick SHALL equal enable.
REQ-016 counter SHALL change only on an edge where tick or load is high.
REQ-017 On tick with up = 1: counter+1; with up = 0: counter-1; arithmetic modulo 2^WIDTH before mode rules.
REQ-018 WRAP = 1: MAX (2^WIDTH-1) + 1 -> 0; 0 - 1 -> MAX.
REQ-019 WRAP = 0: increment at MAX holds MAX; decrement at 0 holds 0.
REQ-020 terminal SHALL equal tick AND ((up AND counter == MAX) OR (NOT up AND counter == 0)), both modes.
REQ-021 saturated SHALL set on an edge where WRAP = 0 and terminal = 1; it SHALL clear on any tick that moves counter off the limit, and on load.
REQ-022 saturated SHALL remain 0 permanently when WRAP = 1.
REQ-023 load SHALL take priority over tick: counter <= load_value, prescaler <= 0, saturated <= 0, regardless of enable.
REQ-024 While load is high, terminal SHALL be forced 0.
REQ-025 Direction change between ticks SHALL take effect on the next tick; prescaler phase SHALL be unaffected by up.
REQ-026 Latency: load_value visible on counter one cycle after the load edge; count step visible one cycle after the tick edge.

Reset
REQ-027 reset_ SHALL take priority over load, tick and enable.
REQ-028 On a reset_ edge: counter <= 0, prescaler <= 0, saturated <= 0; tick and terminal follow from the reset state.
REQ-029 Reset asserted mid-prescale SHALL discard the partial prescale phase; the first tick after release occurs PRESCALE enabled cycles later.

Structure
REQ-030 Shared package SHALL hold the mode constants (MODE_WRAP = 1, MODE_SATURATE = 0) and a width-parametrised limit helper (MAX for WIDTH).
REQ-031 Prescaler SHALL be a sub-module named clock_prescaler (params PRESCALE; ports clock, reset_, enable, clear, tick).
REQ-032 clear on clock_prescaler SHALL be driven by load.

Verification (WIDTH = 4, PRESCALE = 3 unless stated)
REQ-033 Reset, enable = 1, up = 1 for 9 cycles -> tick on cycles 3, 6, 9; counter 0 -> 1 -> 2 -> 3.
REQ-034 WRAP = 1, load 14, up = 1, 6 enabled cycles -> counter 15, then 0; terminal high on the tick at 15.
REQ-035 WRAP = 0, load 1, up = 0, 9 enabled cycles -> counter 0, held 0; terminal high on the ticks at 0; saturated = 1 after the first such tick; then up = 1 tick -> counter 1, saturated = 0.
REQ-036 load = 1 with load_value = 9 on the same edge as a tick -> counter = 9, prescaler = 0, terminal = 0; next tick 3 enabled cycles later.
REQ-037 enable toggled 1,0,0,1,1 from prescaler = 0 -> exactly one tick, on the last cycle; counter frozen while enable = 0.
REQ-038 reset_ and load both high mid-prescale with counter = 7 -> counter = 0, saturated = 0; first tick after release 3 cycles later.

Source files
------------

// File: rtl/prescaled_updown_counter_pkg.sv
// Shared constants and helpers for the prescaled up/down counter.
package prescaled_updown_counter_pkg;

  // Counter overflow behaviour selected by the WRAP parameter.
  localparam int MODE_WRAP     = 1;
  localparam int MODE_SATURATE = 0;

  // All-ones limit for a counter of the given width (valid for 1..64 bits).
  function automatic logic [63:0] width_max(input int unsigned width);
    logic [63:0] one_v;
    one_v = 64'd1;
    if (width >= 32'd64) begin
      width_max = {64{1'b1}};
    end else begin
      width_max = (one_v << width) - 64'd1;
    end
  endfunction

endpackage

// File: rtl/prescaled_updown_counter_clock_prescaler.sv
// Clock-enable divider: strobes tick once every PRESCALE enabled cycles.
module clock_prescaler
  import prescaled_updown_counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset_,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  // A single-state prescaler still needs a one-bit register to stay legal.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next phase: clear wins over enable so a load restarts the prescale period.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CW{1'b0}};
    end else if (enable) begin
      if (count_q == LAST) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
  end

  // Phase register with synchronous reset discarding any partial period.
  always_ff @(posedge clock) begin
    if (reset_) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Strobe on the last phase of the period while enabled.
  always_comb begin
    tick = enable && (count_q == LAST);
  end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Up/down counter advanced by a prescaled enable, with wrap or saturate mode.
module prescaled_updown_counter
  import prescaled_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 4,
  parameter int WRAP     = 1
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             tick,
  output logic             terminal,
  output logic             saturated
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(width_max(WIDTH));
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               SAT_MODE = (WRAP == MODE_SATURATE);

  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_d;
  logic             saturated_q;
  logic             saturated_d;
  logic             tick_s;
  logic             at_limit_s;

  // Load restarts the prescale phase so the next tick is a full period away.
  clock_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset_ (reset_),
    .enable (enable),
    .clear  (load),
    .tick   (tick_s)
  );

  // Boundary detection in the current direction; load masks the pulse.
  always_comb begin
    if (up) begin
      at_limit_s = (counter_q == MAX);
    end else begin
      at_limit_s = (counter_q == ZERO);
    end
    terminal = tick_s && !load && at_limit_s;
    tick     = tick_s;
  end

  // Next count and saturation flag: load beats tick, saturate mode holds at limits.
  always_comb begin
    counter_d   = counter_q;
    saturated_d = saturated_q;
    if (load) begin
      counter_d   = load_value;
      saturated_d = 1'b0;
    end else if (tick_s) begin
      if (SAT_MODE && at_limit_s) begin
        counter_d   = counter_q;
        saturated_d = 1'b1;
      end else begin
        if (up) begin
          counter_d = counter_q + ONE;
        end else begin
          counter_d = counter_q - ONE;
        end
        saturated_d = 1'b0;
      end
    end else begin
      counter_d   = counter_q;
      saturated_d = saturated_q;
    end
    if (!SAT_MODE) begin
      saturated_d = 1'b0;
    end else begin
      saturated_d = saturated_d;
    end
  end

  // Count and flag registers; synchronous reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset_) begin
      counter_q   <= ZERO;
      saturated_q <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      saturated_q <= saturated_d;
    end
  end

  // Registered outputs.
  always_comb begin
    counter   = counter_q;
    saturated = saturated_q;
  end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Scoreboard bench: a wrap-mode and a saturate-mode instance share stimulus.
module tb_prescaled_updown_counter;

  localparam int W = 4;
  localparam int P = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_;
  logic         enable;
  logic         up;
  logic         load;
  logic [W-1:0] load_value;

  logic [W-1:0] cnt_w, cnt_s;
  logic         tick_w, tick_s, term_w, term_s, sat_w, sat_s;

  prescaled_updown_counter #(.WIDTH(W), .PRESCALE(P), .WRAP(1)) dut_wrap (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .counter(cnt_w), .tick(tick_w),
    .terminal(term_w), .saturated(sat_w)
  );

  prescaled_updown_counter #(.WIDTH(W), .PRESCALE(P), .WRAP(0)) dut_sat (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .counter(cnt_s), .tick(tick_s),
    .terminal(term_s), .saturated(sat_s)
  );

  typedef struct packed {
    logic [W-1:0] cw;
    logic         sw;
    logic [W-1:0] cs;
    logic         ss;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int           m_pre = 0;
  logic [W-1:0] m_cw  = '0;
  logic [W-1:0] m_cs  = '0;
  logic         m_sw  = 1'b0;
  logic         m_ss  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, push expectation, check registers.
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [W-1:0] lv);
    exp_t ex;
    exp_t got;
    logic mt, mtw, mts;
    int   npre;
    @(negedge clock);
    reset_ = r; enable = e; up = u; load = l; load_value = lv;
    #1;
    mt  = e && (m_pre == P - 1);
    mtw = mt && !l && ((u && m_cw == 4'hF) || (!u && m_cw == 4'h0));
    mts = mt && !l && ((u && m_cs == 4'hF) || (!u && m_cs == 4'h0));
    check_eq("tick_w", {31'd0, tick_w}, {31'd0, mt});
    check_eq("tick_s", {31'd0, tick_s}, {31'd0, mt});
    check_eq("term_w", {31'd0, term_w}, {31'd0, mtw});
    check_eq("term_s", {31'd0, term_s}, {31'd0, mts});

    ex.cw = m_cw; ex.sw = 1'b0; ex.cs = m_cs; ex.ss = m_ss;
    npre  = m_pre;
    if (r) begin
      npre = 0; ex.cw = 4'h0; ex.cs = 4'h0; ex.ss = 1'b0;
    end else if (l) begin
      npre = 0; ex.cw = lv; ex.cs = lv; ex.ss = 1'b0;
    end else begin
      if (e) npre = (m_pre == P - 1) ? 0 : m_pre + 1;
      if (mt) begin
        ex.cw = u ? m_cw + 4'h1 : m_cw - 4'h1;
        if (mts) begin
          ex.ss = 1'b1;
        end else begin
          ex.cs = u ? m_cs + 4'h1 : m_cs - 4'h1;
          ex.ss = 1'b0;
        end
      end
    end
    sb_q.push_back(ex);

    @(posedge clock);
    #1;
    check_eq("sb_depth", sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check_eq("cnt_w", {28'd0, cnt_w}, {28'd0, got.cw});
      check_eq("sat_w", {31'd0, sat_w}, {31'd0, got.sw});
      check_eq("cnt_s", {28'd0, cnt_s}, {28'd0, got.cs});
      check_eq("sat_s", {31'd0, sat_s}, {31'd0, got.ss});
      m_cw = got.cw; m_cs = got.cs; m_ss = got.ss; m_sw = got.sw;
    end
    m_pre = npre;
  endtask

  initial begin
    reset_ = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = '0;

    // Reset
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    check_eq("rst_cnt", {28'd0, cnt_w}, 32'd0);
    check_eq("rst_sat", {31'd0, sat_s}, 32'd0);

    // Nine enabled up cycles: ticks on 3, 6, 9
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check_eq("r033_cnt", {28'd0, cnt_w}, 32'd3);

    // Wrap through MAX
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd14);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check_eq("r034_wrap", {28'd0, cnt_w}, 32'd0);
    check_eq("r034_satc", {28'd0, cnt_s}, 32'd15);
    check_eq("r034_satf", {31'd0, sat_s}, 32'd1);

    // Saturate at zero, then move off the limit
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check_eq("r035_cnt0", {28'd0, cnt_s}, 32'd0);
    check_eq("r035_sat1", {31'd0, sat_s}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check_eq("r035_cnt1", {28'd0, cnt_s}, 32'd1);
    check_eq("r035_sat0", {31'd0, sat_s}, 32'd0);

    // Load coinciding with a tick
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
    check_eq("r036_cnt", {28'd0, cnt_w}, 32'd9);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check_eq("r036_next", {28'd0, cnt_w}, 32'd10);

    // Enable pattern 1,0,0,1,1 from phase 0
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_eq("r037_frozen", {28'd0, cnt_w}, 32'd10);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check_eq("r037_cnt", {28'd0, cnt_w}, 32'd11);

    // Reset and load together mid-prescale
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
    check_eq("r038_cnt", {28'd0, cnt_w}, 32'd0);
    check_eq("r038_sat", {31'd0, sat_s}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check_eq("r038_tick", {28'd0, cnt_w}, 32'd1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
